// File: rtl/matrix_key_scan_if.sv
// Keypad scanner bus: row/column lines toward the keypad plus the decoded
// key outputs. "master" is the scanner side, "slave" the keypad/consumer side.
interface matrix_key_scan_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic [7:0] data_out;

    modport master (
        input  row,
        output col, key_code, key_valid, key_down, data_out
    );

    modport slave (
        output row,
        input  col, key_code, key_valid, key_down, data_out
    );
endinterface

// File: rtl/matrix_key_scan.sv
// 4x4 active-low matrix keypad scanner with frame-based debounce.
// Drives one column low per step and samples the rows. Whole-frame
// snapshots of the 16 keys are classified as none / single / multi, and
// debounced before being reported as a hex code.
// Optional build macro KEY_REPEAT_EN adds auto-repeat pulses while a key is
// held (every REPEAT_FRAMES non-empty frames).
// rst_n is expected to be released synchronously to clk by the reset source.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | no key accepted; waiting for a single-key frame
// PRESS_CHK   | counting consecutive frames showing the same single key
// HELD        | key accepted and reported; key_down high
// RELEASE_CHK | counting consecutive empty frames before dropping key_down
module matrix_key_scan #(
    parameter int SCAN_DIV      = 1000,
    parameter int DEB_FRAMES    = 8,
    parameter int REPEAT_FRAMES = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    matrix_key_scan_if.master kbd
);
    localparam int                STEP_W    = $clog2(SCAN_DIV);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SCAN_DIV - 1);
    localparam logic [3:0]        DEB_N     = 4'(DEB_FRAMES);

    if (SCAN_DIV < 4) begin : g_bad_div
        $error("matrix_key_scan: SCAN_DIV must be at least 4");
    end
    if (DEB_FRAMES < 1 || DEB_FRAMES > 15) begin : g_bad_deb
        $error("matrix_key_scan: DEB_FRAMES must be in 1..15");
    end
    if (REPEAT_FRAMES < 1) begin : g_bad_rpt
        $error("matrix_key_scan: REPEAT_FRAMES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    logic [3:0]        row_s1, row_s2;
    logic [STEP_W-1:0] step_cnt;
    logic [1:0]        col_idx;
    logic [3:0]        col_q;
    logic [2:0][3:0]   samp;
    logic              step_end, frame_end;

    logic [15:0]       hit;
    logic [4:0]        hit_cnt;
    logic [3:0]        hit_code;
    logic              is_none, is_single;

    state_t            state, state_nxt;
    logic [3:0]        cand, cand_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [3:0]        rel, rel_nxt;
    logic [3:0]        acc_code;
    logic              do_accept, do_release, do_repeat;

    logic [3:0]        key_code_q;
    logic              key_valid_q, key_down_q;
    logic [7:0]        data_q;

    // two-flop synchroniser on the asynchronous row lines (idle = pulled up)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= kbd.row;
            row_s2 <= row_s1;
        end
    end

    assign step_end  = (step_cnt == STEP_LAST);
    assign frame_end = step_end && (col_idx == 2'd3);

    // column stepping; rows of columns 0..2 are stored, column 3 is used live
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
            col_idx  <= '0;
            col_q    <= 4'b1110;
            samp     <= '1;
        end else if (step_end) begin
            step_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
            col_q    <= {col_q[2:0], col_q[3]};
            case (col_idx)
                2'd0:    samp[0] <= row_s2;
                2'd1:    samp[1] <= row_s2;
                2'd2:    samp[2] <= row_s2;
                default: ;
            endcase
        end else begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    // frame snapshot: bit row*4+col set when that key is closed
    always_comb begin
        hit = '0;
        for (int r = 0; r < 4; r++) begin
            hit[r*4 + 0] = ~samp[0][r];
            hit[r*4 + 1] = ~samp[1][r];
            hit[r*4 + 2] = ~samp[2][r];
            hit[r*4 + 3] = ~row_s2[r];
        end
    end

    // count closed keys and locate one of them (only meaningful when single)
    always_comb begin
        hit_cnt  = '0;
        hit_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (hit[i]) begin
                hit_cnt  = hit_cnt + 5'd1;
                hit_code = 4'(i);
            end
        end
    end

    assign is_none   = (hit_cnt == 5'd0);
    assign is_single = (hit_cnt == 5'd1);

    // debounce state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
            rel   <= '0;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            cnt   <= cnt_nxt;
            rel   <= rel_nxt;
        end
    end

    // debounce next-state decode, evaluated only at frame end
    always_comb begin
        state_nxt  = state;
        cand_nxt   = cand;
        cnt_nxt    = cnt;
        rel_nxt    = rel;
        acc_code   = cand;
        do_accept  = 1'b0;
        do_release = 1'b0;
        if (frame_end) begin
            unique case (state)
                IDLE: begin
                    if (is_single) begin
                        cand_nxt = hit_code;
                        acc_code = hit_code;
                        if (DEB_N == 4'd1) begin
                            state_nxt = HELD;
                            cnt_nxt   = DEB_N;
                            do_accept = 1'b1;
                        end else begin
                            state_nxt = PRESS_CHK;
                            cnt_nxt   = 4'd1;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (is_single && hit_code == cand) begin
                        cnt_nxt = cnt + 4'd1;
                        if (cnt + 4'd1 == DEB_N) begin
                            state_nxt = HELD;
                            do_accept = 1'b1;
                        end
                    end else if (is_single) begin
                        cand_nxt = hit_code;
                        cnt_nxt  = 4'd1;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                HELD: begin
                    if (is_none) begin
                        if (DEB_N == 4'd1) begin
                            state_nxt  = IDLE;
                            cnt_nxt    = '0;
                            do_release = 1'b1;
                        end else begin
                            state_nxt = RELEASE_CHK;
                            rel_nxt   = 4'd1;
                        end
                    end
                end
                RELEASE_CHK: begin
                    if (is_none) begin
                        if (rel + 4'd1 == DEB_N) begin
                            state_nxt  = IDLE;
                            rel_nxt    = '0;
                            cnt_nxt    = '0;
                            do_release = 1'b1;
                        end else begin
                            rel_nxt = rel + 4'd1;
                        end
                    end else begin
                        state_nxt = HELD;
                        rel_nxt   = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int               RPT_W = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RPT_W-1:0] RPT_N = RPT_W'(REPEAT_FRAMES);

    logic [RPT_W-1:0] rpt, rpt_nxt;

    // repeat counter advances on non-empty frames in HELD, clears otherwise
    always_comb begin
        rpt_nxt   = rpt;
        do_repeat = 1'b0;
        if (frame_end) begin
            if (state == HELD && !is_none) begin
                if (rpt + 1'b1 == RPT_N) begin
                    rpt_nxt   = '0;
                    do_repeat = 1'b1;
                end else begin
                    rpt_nxt = rpt + 1'b1;
                end
            end else begin
                rpt_nxt = '0;
            end
        end
    end

    // repeat counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rpt <= '0;
        else        rpt <= rpt_nxt;
    end
`else
    assign do_repeat = 1'b0;
`endif

    // registered key outputs; data_out shifts in every reported code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            data_q      <= '0;
        end else begin
            key_valid_q <= do_accept | do_repeat;
            if (do_accept) begin
                key_code_q <= acc_code;
                key_down_q <= 1'b1;
                data_q     <= {data_q[3:0], acc_code};
            end else if (do_repeat) begin
                data_q <= {data_q[3:0], key_code_q};
            end
            if (do_release) key_down_q <= 1'b0;
        end
    end

    assign kbd.col       = col_q;
    assign kbd.key_code  = key_code_q;
    assign kbd.key_valid = key_valid_q;
    assign kbd.key_down  = key_down_q;
    assign kbd.data_out  = data_q;
endmodule
